// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared definitions for the EX-stage forwarding/hazard control slice:
// select encodings for the Mux_3_1 operand muxes and the default index width.
package fwd_hazard_ctrl_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

endpackage

// File: rtl/fwd_sel_resolve.sv
// Per-operand forwarding select: compares one source index against the EX
// and MEM producers; the younger (EX) producer wins.
module fwd_sel_resolve
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_W = fwd_hazard_ctrl_pkg::REG_W
) (
    input  logic [REG_W-1:0] src,
    input  logic             src_used,
    input  logic             ex_valid,
    input  logic             ex_we,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             mem_valid,
    input  logic             mem_we,
    input  logic [REG_W-1:0] mem_rt,
    output fwd_sel_t         sel
);

    always_comb begin
        // NOTE: default first so every path assigns sel and no latch is inferred.
        sel = FWD_RF;
        if (src_used && ex_valid && ex_we && (ex_rt == src)) begin
            sel = FWD_EXMEM;
        end else if (src_used && mem_valid && mem_we && (mem_rt == src)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Tracks EX/MEM destination registers, registers the EX operand-mux selects
// and raises a load-use stall with a free-running stall-cycle counter.
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_W = fwd_hazard_ctrl_pkg::REG_W,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_ra,
    input  logic             id_ra_used,
    input  logic [REG_W-1:0] id_rb,
    input  logic             id_rb_used,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush,
    output logic             stall,
    output logic [1:0]       fwd_sel_a,
    output logic [1:0]       fwd_sel_b,
    output logic [CNT_W-1:0] stall_count
);

    logic             ex_valid;
    logic [REG_W-1:0] ex_rt;
    logic             ex_we;
    logic             ex_ld;
    logic             mem_valid;
    logic [REG_W-1:0] mem_rt;
    logic             mem_we;

    fwd_sel_t sel_a_nxt;
    fwd_sel_t sel_b_nxt;
    logic     load_use;

    fwd_sel_resolve #(.REG_W(REG_W)) u_sel_a (
        .src       (id_ra),
        .src_used  (id_ra_used),
        .ex_valid  (ex_valid),
        .ex_we     (ex_we),
        .ex_rt     (ex_rt),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_rt    (mem_rt),
        .sel       (sel_a_nxt)
    );

    fwd_sel_resolve #(.REG_W(REG_W)) u_sel_b (
        .src       (id_rb),
        .src_used  (id_rb_used),
        .ex_valid  (ex_valid),
        .ex_we     (ex_we),
        .ex_rt     (ex_rt),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_rt    (mem_rt),
        .sel       (sel_b_nxt)
    );

    // A load result is not available until MEM, so a dependent in ID must wait one cycle.
    assign load_use = (id_ra_used && (id_ra == ex_rt)) || (id_rb_used && (id_rb == ex_rt));
    assign stall    = id_valid && ex_valid && ex_we && ex_ld && load_use && !flush;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_rt       <= '0;
            ex_we       <= 1'b0;
            ex_ld       <= 1'b0;
            mem_valid   <= 1'b0;
            mem_rt      <= '0;
            mem_we      <= 1'b0;
            fwd_sel_a   <= FWD_RF;
            fwd_sel_b   <= FWD_RF;
            stall_count <= '0;
        end else begin
            // The older instruction always advances, even on flush or stall.
            mem_valid <= ex_valid;
            mem_rt    <= ex_rt;
            mem_we    <= ex_we;
            if (flush || stall) begin
                ex_valid  <= 1'b0;
                fwd_sel_a <= FWD_RF;
                fwd_sel_b <= FWD_RF;
                if (stall) begin
                    stall_count <= stall_count + CNT_W'(1);
                end
            end else begin
                ex_valid  <= id_valid;
                ex_rt     <= id_rt;
                ex_we     <= id_reg_write;
                ex_ld     <= id_mem_read;
                fwd_sel_a <= sel_a_nxt;
                fwd_sel_b <= sel_b_nxt;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed vector table, randomized run against an
// instruction-history model, and counter wrap on a narrow-counter instance.
module tb_fwd_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_ra;
    logic        id_ra_used;
    logic [4:0]  id_rb;
    logic        id_rb_used;
    logic [4:0]  id_rt;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        flush;
    logic        stall;
    logic [1:0]  fwd_sel_a;
    logic [1:0]  fwd_sel_b;
    logic [31:0] stall_count;

    logic        w_reset;
    logic        w_valid;
    logic [4:0]  w_ra;
    logic        w_ra_used;
    logic [4:0]  w_rb;
    logic        w_rb_used;
    logic [4:0]  w_rt;
    logic        w_we;
    logic        w_ld;
    logic        w_flush;
    logic        w_stall;
    logic [1:0]  w_sel_a;
    logic [1:0]  w_sel_b;
    logic [2:0]  w_count;

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.REG_W(5), .CNT_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_ra        (id_ra),
        .id_ra_used   (id_ra_used),
        .id_rb        (id_rb),
        .id_rb_used   (id_rb_used),
        .id_rt        (id_rt),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .stall        (stall),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b),
        .stall_count  (stall_count)
    );

    fwd_hazard_ctrl #(.REG_W(5), .CNT_W(3)) dut_w (
        .clk          (clk),
        .reset        (w_reset),
        .id_valid     (w_valid),
        .id_ra        (w_ra),
        .id_ra_used   (w_ra_used),
        .id_rb        (w_rb),
        .id_rb_used   (w_rb_used),
        .id_rt        (w_rt),
        .id_reg_write (w_we),
        .id_mem_read  (w_ld),
        .flush        (w_flush),
        .stall        (w_stall),
        .fwd_sel_a    (w_sel_a),
        .fwd_sel_b    (w_sel_b),
        .stall_count  (w_count)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: history of what entered EX ----------------
    typedef struct {
        bit       v;
        bit       we;
        bit       ld;
        bit [4:0] rt;
    } prod_t;

    prod_t       hist[$];
    bit [1:0]    m_sel_a;
    bit [1:0]    m_sel_b;
    int unsigned m_cnt;
    bit          m_stall;

    function automatic prod_t bubble();
        prod_t p;
        p.v = 0; p.we = 0; p.ld = 0; p.rt = '0;
        return p;
    endfunction

    function automatic void model_reset();
        hist.delete();
        hist.push_back(bubble());
        hist.push_back(bubble());
        m_sel_a = 2'b00;
        m_sel_b = 2'b00;
        m_cnt   = 0;
    endfunction

    // Youngest producer (age 0, in EX) first, then the one in MEM (age 1).
    function automatic bit [1:0] model_sel(input bit [4:0] src, input bit used);
        for (int age = 0; age < 2; age++) begin
            prod_t p = hist[hist.size() - 1 - age];
            if (used && p.v && p.we && p.rt == src) return (age == 0) ? 2'b01 : 2'b10;
        end
        return 2'b00;
    endfunction

    function automatic bit model_stall();
        prod_t p = hist[hist.size() - 1];
        bit dep = (id_ra_used && id_ra == p.rt) || (id_rb_used && id_rb == p.rt);
        return id_valid && p.v && p.we && p.ld && dep && !flush;
    endfunction

    function automatic void model_update(input bit st);
        prod_t p;
        if (reset) begin
            model_reset();
            return;
        end
        if (flush || st) begin
            hist.push_back(bubble());
            m_sel_a = 2'b00;
            m_sel_b = 2'b00;
            if (!flush) m_cnt = m_cnt + 1;
        end else begin
            m_sel_a = model_sel(id_ra, id_ra_used);
            m_sel_b = model_sel(id_rb, id_rb_used);
            p.v = id_valid; p.we = id_reg_write; p.ld = id_mem_read; p.rt = id_rt;
            hist.push_back(p);
        end
        while (hist.size() > 2) void'(hist.pop_front());
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rst, v;
        bit [4:0]    ra;
        bit          rau;
        bit [4:0]    rb;
        bit          rbu;
        bit [4:0]    rt;
        bit          we, ld, fl;
        bit          e_stall;
        bit [1:0]    e_a, e_b;
        int unsigned e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit rst, v, input int ra, input bit rau, input int rb,
                                input bit rbu, input int rt, input bit we, ld, fl,
                                input bit e_stall, input bit [1:0] e_a, e_b, input int unsigned e_cnt);
        vec_t t;
        t.rst = rst; t.v = v; t.ra = 5'(ra); t.rau = rau; t.rb = 5'(rb); t.rbu = rbu;
        t.rt = 5'(rt); t.we = we; t.ld = ld; t.fl = fl;
        t.e_stall = e_stall; t.e_a = e_a; t.e_b = e_b; t.e_cnt = e_cnt;
        tbl.push_back(t);
    endfunction

    task automatic drive(input bit rst, v, input bit [4:0] ra, input bit rau, input bit [4:0] rb,
                         input bit rbu, input bit [4:0] rt, input bit we, ld, fl);
        reset = rst; id_valid = v; id_ra = ra; id_ra_used = rau; id_rb = rb; id_rb_used = rbu;
        id_rt = rt; id_reg_write = we; id_mem_read = ld; flush = fl;
    endtask

    // Inputs are driven just after negedge; stall is sampled 1 time unit later,
    // registered outputs 1 time unit after the rising edge.
    task automatic run_cycle(output logic got_stall);
        #1;
        got_stall = stall;
        m_stall   = model_stall();
        @(posedge clk);
        model_update(m_stall);
        #1;
    endtask

    task automatic w_drive(input bit v, input bit [4:0] ra, input bit rau, input bit [4:0] rt,
                           input bit we, ld);
        w_valid = v; w_ra = ra; w_ra_used = rau; w_rb = '0; w_rb_used = 1'b0;
        w_rt = rt; w_we = we; w_ld = ld; w_flush = 1'b0;
    endtask

    initial begin
        logic s;

        // rst  v  ra rau rb rbu rt we ld fl | stall a     b     cnt
        add(1, 0,  0, 0,  0, 0,  0, 0, 0, 0,   0, 2'b00, 2'b00, 0); // reset state
        add(0, 1,  1, 1,  2, 1,  3, 1, 0, 0,   0, 2'b00, 2'b00, 0); // add r3,r1,r2
        add(0, 1,  3, 1,  4, 1,  5, 1, 0, 0,   0, 2'b01, 2'b00, 0); // add r5,r3,r4
        add(0, 0,  0, 0,  0, 0,  0, 0, 0, 0,   0, 2'b00, 2'b00, 0); // nop
        add(0, 1,  9, 1, 10, 1,  3, 1, 0, 0,   0, 2'b00, 2'b00, 0); // add r3,r9,r10
        add(0, 0,  0, 0,  0, 0,  0, 0, 0, 0,   0, 2'b00, 2'b00, 0); // nop
        add(0, 1,  3, 1,  3, 1,  7, 1, 0, 0,   0, 2'b10, 2'b10, 0); // add r7,r3,r3
        add(0, 1,  1, 1,  0, 0,  6, 1, 1, 0,   0, 2'b00, 2'b00, 0); // ld r6
        add(0, 1,  6, 1,  2, 1,  8, 1, 0, 0,   1, 2'b00, 2'b00, 1); // add r8,r6,r2 stalls
        add(0, 1,  6, 1,  2, 1,  8, 1, 0, 0,   0, 2'b10, 2'b00, 1); // reissue: load in MEM
        add(0, 1, 11, 1, 12, 1,  4, 1, 0, 0,   0, 2'b00, 2'b00, 1); // add r4 (older)
        add(0, 1, 13, 1, 14, 1,  4, 1, 0, 0,   0, 2'b00, 2'b00, 1); // add r4 (younger)
        add(0, 1,  4, 1,  4, 1,  9, 1, 0, 0,   0, 2'b01, 2'b01, 1); // EX beats MEM
        add(0, 1,  1, 1,  0, 0,  6, 1, 1, 0,   0, 2'b00, 2'b00, 1); // ld r6
        add(0, 1,  6, 1,  2, 1,  8, 1, 0, 1,   0, 2'b00, 2'b00, 1); // consumer + flush
        add(0, 1,  8, 1,  6, 1, 10, 1, 0, 0,   0, 2'b00, 2'b10, 1); // flushed r8 gone, ld in MEM
        add(0, 1,  1, 1,  0, 0,  6, 1, 1, 0,   0, 2'b00, 2'b00, 1); // ld r6
        add(1, 1,  6, 1,  2, 1,  8, 1, 0, 0,   1, 2'b00, 2'b00, 0); // reset during stall
        add(0, 1,  6, 1,  2, 1,  8, 1, 0, 0,   0, 2'b00, 2'b00, 0); // state cleared
        add(0, 1,  1, 1,  2, 1,  0, 1, 0, 0,   0, 2'b00, 2'b00, 0); // add r0,r1,r2
        add(0, 1,  0, 1,  8, 1, 15, 1, 0, 0,   0, 2'b01, 2'b10, 0); // r0 matches; independent
        add(0, 1,  0, 0,  0, 1, 16, 1, 0, 0,   0, 2'b00, 2'b10, 0); // RA literal ignored

        drive(1, 0, '0, 0, '0, 0, '0, 0, 0, 0);
        w_reset = 1'b1;
        w_drive(0, '0, 0, '0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        w_reset = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].v, tbl[i].ra, tbl[i].rau, tbl[i].rb, tbl[i].rbu,
                  tbl[i].rt, tbl[i].we, tbl[i].ld, tbl[i].fl);
            run_cycle(s);
            check($sformatf("vec%0d stall", i), 32'(s), 32'(tbl[i].e_stall));
            check($sformatf("vec%0d sel_a", i), 32'(fwd_sel_a), 32'(tbl[i].e_a));
            check($sformatf("vec%0d sel_b", i), 32'(fwd_sel_b), 32'(tbl[i].e_b));
            check($sformatf("vec%0d count", i), stall_count, tbl[i].e_cnt);
        end

        for (int n = 0; n < 400; n++) begin
            bit we;
            @(negedge clk);
            we = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 59) == 0, $urandom_range(0, 7) != 0,
                  5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
                  5'($urandom_range(0, 7)), we, we && ($urandom_range(0, 2) == 0),
                  $urandom_range(0, 9) == 0);
            run_cycle(s);
            check($sformatf("rnd%0d stall", n), 32'(s), 32'(m_stall));
            check($sformatf("rnd%0d sel_a", n), 32'(fwd_sel_a), 32'(m_sel_a));
            check($sformatf("rnd%0d sel_b", n), 32'(fwd_sel_b), 32'(m_sel_b));
            check($sformatf("rnd%0d count", n), stall_count, m_cnt);
        end

        // Narrow counter: eight load-use stalls take 3'b111 back to 0.
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            w_drive(1, 5'd1, 1, 5'd6, 1, 1);
            @(negedge clk);
            w_drive(1, 5'd6, 1, 5'd8, 1, 0);
            #1;
            check($sformatf("wrap%0d stall", k), 32'(w_stall), 32'd1);
            @(posedge clk);
            #1;
            check($sformatf("wrap%0d count", k), 32'(w_count), 32'(k % 8));
            @(negedge clk);
            w_drive(0, '0, 0, '0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
